// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   Single-port SRAM with a valid/ready request interface, byte-enable writes,
//   a configurable read latency and out-of-range detection. After reset a
//   hardware sweep writes INIT_VAL to every word before requests are accepted.
//
// Parameters
//   DW        data width in bits (multiple of 8)
//   DEPTH     number of words (any value with 2**AW >= DEPTH)
//   AW        address width
//   READ_LAT  cycles from read acceptance to rsp_valid (1..4)
//   INIT_VAL  value written to every word during the init sweep
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  block accepts a request this cycle (high only once initialised)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte enables for writes (bit k covers bits [8k+7:8k])
//   rsp_valid  one-cycle pulse per read response
//   rsp_data   read data; holds its last value while rsp_valid is low
//   rsp_err    read address was out of range (qualified by rsp_valid)
//   init_done  init sweep complete
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int              DW       = 32,
    parameter int              DEPTH    = 256,
    parameter int              AW       = 8,
    parameter int              READ_LAT = 1,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int NB = DW / 8;
    // One extra bit so the range compare also works when DEPTH == 2**AW.
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          in_range;
    logic          rd_acc;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_be;

    // Read pipeline: stage 0 is the registered memory output, later stages
    // delay it. Data/err stages only load when the upstream stage is valid, so
    // the last stage naturally holds the previous response between pulses.
    logic          pipe_vld_q  [READ_LAT];
    logic          pipe_vld_d  [READ_LAT];
    logic          pipe_err_q  [READ_LAT];
    logic          pipe_err_d  [READ_LAT];
    logic [DW-1:0] pipe_data_q [READ_LAT];
    logic [DW-1:0] pipe_data_d [READ_LAT];

    assign req_ready = (state_q == S_RUN);
    assign init_done = (state_q == S_RUN);

    assign accept   = req_valid && req_ready && !rst;
    assign in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign rd_acc   = accept && !req_we;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // --------------------------------------------------------- write port
    // The init sweep and bus writes share the single write port; they never
    // collide because requests are refused while the sweep runs.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_data = INIT_VAL;
        wr_be   = '1;
        if (!rst) begin
            if (state_q == S_INIT) begin
                wr_en = 1'b1;
            end else if (accept && req_we && in_range) begin
                wr_en   = 1'b1;
                wr_addr = req_addr;
                wr_data = req_wdata;
                wr_be   = req_be;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------- read pipeline
    always_comb begin
        for (int i = 0; i < READ_LAT; i++) begin
            pipe_vld_d[i]  = 1'b0;
            pipe_err_d[i]  = pipe_err_q[i];
            pipe_data_d[i] = pipe_data_q[i];
        end
        pipe_vld_d[0] = rd_acc;
        if (rd_acc) begin
            pipe_err_d[0] = !in_range;
        end
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            if (pipe_vld_q[i-1]) begin
                pipe_err_d[i]  = pipe_err_q[i-1];
                pipe_data_d[i] = pipe_data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_err_q[i]  <= 1'b0;
                pipe_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_d[i];
                pipe_err_q[i] <= pipe_err_d[i];
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
            // Read-before-write: a write accepted on a later edge cannot
            // affect data captured here.
            if (rd_acc) begin
                pipe_data_q[0] <= in_range ? mem[req_addr] : '0;
            end
        end
    end

    assign rsp_valid = pipe_vld_q[READ_LAT-1];
    assign rsp_err   = pipe_err_q[READ_LAT-1];
    assign rsp_data  = pipe_data_q[READ_LAT-1];

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//   Drives three sram_ctrl instances with the same stimulus:
//     u0: DEPTH=256, READ_LAT=1, INIT_VAL=0
//     u1: DEPTH=200, READ_LAT=3, INIT_VAL=0x5A5AC3C3
//     u2: DEPTH=256, READ_LAT=4, INIT_VAL=0xCAFE0001
//   Each instance has a reference model (word array + queue of expected
//   responses with their due cycle). Every cycle all outputs are compared.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        ready_w     [N];
    logic        rsp_valid_w [N];
    logic [31:0] rsp_data_w  [N];
    logic        rsp_err_w   [N];
    logic        init_done_w [N];

    always #5 clk = ~clk;

    sram_ctrl #(.DW(32), .DEPTH(256), .AW(8), .READ_LAT(1), .INIT_VAL(32'h0000_0000)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_w[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]), .rsp_err(rsp_err_w[0]),
        .init_done(init_done_w[0])
    );

    sram_ctrl #(.DW(32), .DEPTH(200), .AW(8), .READ_LAT(3), .INIT_VAL(32'h5A5A_C3C3)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_w[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]), .rsp_err(rsp_err_w[1]),
        .init_done(init_done_w[1])
    );

    sram_ctrl #(.DW(32), .DEPTH(256), .AW(8), .READ_LAT(4), .INIT_VAL(32'hCAFE_0001)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_w[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_w[2]), .rsp_data(rsp_data_w[2]), .rsp_err(rsp_err_w[2]),
        .init_done(init_done_w[2])
    );

    // ----------------------------------------------------- reference model
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    int          dep_m   [N];
    int          lat_m   [N];
    logic [31:0] init_m  [N];
    logic [31:0] exp_mem [N][256];
    rsp_t        exp_q   [N][$];
    int          init_cnt  [N];
    logic [31:0] last_data [N];
    logic        last_err  [N];

    int cyc;
    int tests_run;
    int tests_failed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply the effect of the upcoming clock edge to every model.
    task automatic model_edge();
        int   e;
        rsp_t r;
        e = cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                exp_q[i].delete();
                init_cnt[i]  = 0;
                last_data[i] = 32'h0;
                last_err[i]  = 1'b0;
                for (int a = 0; a < 256; a++) exp_mem[i][a] = init_m[i];
            end else if (init_cnt[i] < dep_m[i]) begin
                init_cnt[i]++;
            end else if (req_valid) begin
                if (i == 0)
                    $display("[TB] cyc %0d %s addr=0x%02h wdata=0x%08h be=0x%1h",
                             e, req_we ? "WR" : "RD", req_addr, req_wdata, req_be);
                if (req_we) begin
                    if (int'(req_addr) < dep_m[i])
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) exp_mem[i][req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end else begin
                    r.due  = e + lat_m[i] - 1;
                    r.err  = (int'(req_addr) >= dep_m[i]);
                    r.data = r.err ? 32'h0 : exp_mem[i][req_addr];
                    exp_q[i].push_back(r);
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_v;
        for (int i = 0; i < N; i++) begin
            exp_v = 1'b0;
            if (exp_q[i].size() > 0 && exp_q[i][0].due == cyc) begin
                exp_v        = 1'b1;
                last_data[i] = exp_q[i][0].data;
                last_err[i]  = exp_q[i][0].err;
                void'(exp_q[i].pop_front());
            end
            check($sformatf("u%0d.req_ready", i), {31'b0, ready_w[i]},     {31'b0, init_cnt[i] >= dep_m[i]});
            check($sformatf("u%0d.init_done", i), {31'b0, init_done_w[i]}, {31'b0, init_cnt[i] >= dep_m[i]});
            check($sformatf("u%0d.rsp_valid", i), {31'b0, rsp_valid_w[i]}, {31'b0, exp_v});
            check($sformatf("u%0d.rsp_data", i),  rsp_data_w[i],            last_data[i]);
            check($sformatf("u%0d.rsp_err", i),   {31'b0, rsp_err_w[i]},    {31'b0, last_err[i]});
        end
    endtask

    task automatic step(input logic r, input logic v, input logic we,
                        input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        rst       = r;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        model_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, 1'b1, a, d, be);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 1'b1, 1'b0, a, $urandom, 4'($urandom));
    endtask

    // Idle until every model reports init complete (bounded).
    task automatic wait_init();
        int k;
        k = 0;
        while ((init_cnt[0] < dep_m[0] || init_cnt[1] < dep_m[1] || init_cnt[2] < dep_m[2]) && k < 400) begin
            idle(1);
            k++;
        end
    endtask

    initial begin
        logic        r, v;
        dep_m  = '{256, 200, 256};
        lat_m  = '{1, 3, 4};
        init_m = '{32'h0000_0000, 32'h5A5A_C3C3, 32'hCAFE_0001};
        cyc          = 0;
        tests_run    = 0;
        tests_failed = 0;

        // Reset for two cycles, then the init sweep (ready/done checked each cycle).
        step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        // Requests during the sweep must be ignored.
        for (int k = 0; k < 20; k++) wr(8'(k), 32'hFFFF_FFFF, 4'hF);
        wait_init();

        // Freshly initialised word.
        rd(8'h7F);
        idle(5);

        // Full write then read on the next cycle.
        wr(8'h03, 32'hDEAD_BEEF, 4'hF);
        rd(8'h03);
        idle(5);

        // Partial write with byte enables 0101.
        wr(8'h03, 32'h1122_3344, 4'h5);
        rd(8'h03);
        idle(5);

        // be=0 is a no-op.
        wr(8'h03, 32'h0000_0000, 4'h0);
        rd(8'h03);
        idle(5);

        // Back-to-back reads of 0..7.
        for (int a = 0; a < 8; a++) wr(8'(a), 32'(a) * 32'h0101_0101, 4'hF);
        for (int a = 0; a < 8; a++) rd(8'(a));
        idle(6);

        // Read then write the same address on the next edge: old data returned.
        rd(8'h05);
        wr(8'h05, 32'hABCD_0123, 4'hF);
        rd(8'h05);
        idle(6);

        // Out of range for u1 (DEPTH=200), in range for the others.
        wr(8'd210, 32'hFFFF_FFFF, 4'hF);
        rd(8'd210);
        rd(8'd199);
        rd(8'd255);
        idle(6);

        // Randomized traffic, with an occasional reset.
        for (int k = 0; k < 1500; k++) begin
            r = ($urandom_range(0, 699) == 0);
            v = !r && ($urandom_range(0, 3) != 0);
            step(r, v, 1'($urandom), 8'($urandom), $urandom, 4'($urandom));
        end
        wait_init();

        // Reset while reads are in flight, then check re-initialisation.
        wr(8'h05, 32'h1234_5678, 4'hF);
        rd(8'h05);
        rd(8'h05);
        rd(8'h05);
        step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        idle(10);
        wait_init();
        rd(8'h05);
        rd(8'h03);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Parametrised single-port SRAM block with a valid/ready request interface, byte-enable writes, a configurable read latency, and out-of-range detection. After reset, a hardware sweep initialises every location before any request is accepted. It replaces the fixed 8-bit/256-entry memory in the memory subsystem and sits between bus-side masters and the storage array.

Parameters:
DW, 32, data width in bits; must be a multiple of 8.
DEPTH, 256, number of words; need not be a power of two.
AW, 8, address width; must satisfy 2**AW >= DEPTH.
READ_LAT, 1, read latency in cycles from request acceptance to response; legal range 1..4.
INIT_VAL, 0, DW-bit value written to every word during the init sweep.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  AW  word address.
req_wdata  in  DW  write data.
req_be  in  DW/8  byte enables for writes; bit k covers data bits [8k+7:8k].
rsp_valid  out  1  read response valid; a one-cycle pulse per read.
rsp_data  out  DW  read data.
rsp_err  out  1  the read address was out of range; qualified by rsp_valid.
init_done  out  1  init sweep complete.

Behaviour:
- Reset (rst=1 at an edge): FSM goes to INIT and the init counter is cleared to 0.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0. The read pipeline is flushed, so in-flight reads are dropped.
- INIT state:
  - Each edge with rst=0 writes INIT_VAL to mem[cnt] and increments cnt.
  - The edge that writes DEPTH-1 moves the FSM to RUN.
  - req_ready and init_done go to 1 exactly DEPTH edges after the first edge with rst=0.
  - req_ready=0 throughout INIT.
- RUN state:
  - req_ready=1 constantly.
  - A request is accepted when req_valid && req_ready at an edge; throughput is one request per cycle.
  - init_done stays 1 until the next reset.
- Write:
  - Updates only the bytes whose req_be bit is 1; other bytes keep their old value.
  - req_be=0 is a legal no-op.
  - A write produces no response.
- Read:
  - rsp_valid=1 for exactly one cycle, READ_LAT cycles after the acceptance edge.
  - rsp_data is the memory content as of the acceptance edge. A write accepted on an earlier edge is visible; a read at edge N followed by a write at edge N+1 to the same address returns the old data.
  - Responses return in request order; back-to-back reads give back-to-back rsp_valid pulses.
- rsp_data holds its last value while rsp_valid=0.
- Out of range (req_addr >= DEPTH):
  - A write is ignored; memory is unchanged.
  - A read responds with normal latency, rsp_data=0 and rsp_err=1.
  - rsp_err=0 for every in-range response.
- Reset mid-operation:
  - A pending response pulse never appears.
  - Memory is re-initialised to INIT_VAL.
  - Requests are refused until the new sweep completes.
- req_we, req_addr, req_wdata and req_be are ignored when the request is not accepted.

Test Plan:
- Default parameters; rst high for 2 cycles, then low → init_done=0 and req_ready=0 for 256 edges, both go to 1 on edge 256. Read addr 0x7F → rsp_data=0x00000000, rsp_err=0.
- Write 0xDEADBEEF to addr 0x03 with be=0xF, then read 0x03 on the next cycle → rsp_valid exactly READ_LAT cycles later with 0xDEADBEEF. Repeat with READ_LAT=3 → response 3 cycles after acceptance.
- Word = 0xDEADBEEF; write 0x11223344 with be=0x5, then read → 0xDE22BE44.
- Reads of addrs 0..7 on 8 consecutive cycles after writing the value addr*0x01010101 to each → 8 consecutive rsp_valid pulses with data in order and no gaps.
- DEPTH=200, AW=8: write 0xFFFFFFFF to addr 210 → memory unchanged. Read 210 → rsp_data=0, rsp_err=1. Read 199 → rsp_err=0.
- Issue 3 reads with READ_LAT=4, assert rst one cycle later → no rsp_valid pulse appears. A previously written word reads back as INIT_VAL after init_done rises again.
